// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Controller state: free-running pipeline or waiting on multdiv
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Register x0 is hardwired zero, so it can never carry a hazard
    localparam logic [4:0] ZERO_REG = 5'd0;

    // Width and saturation point of the WAIT cycle counter
    localparam int         MD_CYC_W   = 6;
    localparam logic [5:0] MD_CYC_MAX = 6'h3F;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparison between the DX load and the FD reader.
import pipe_ctrl_pkg::*;

module load_use_detect (
    input  logic       dx_is_load,
    input  logic [4:0] dx_rd,
    input  logic [4:0] fd_rs1,
    input  logic [4:0] fd_rs2,
    input  logic       fd_use_rs1,
    input  logic       fd_use_rs2,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = fd_use_rs1 && (fd_rs1 == dx_rd);
    assign rs2_hit = fd_use_rs2 && (fd_rs2 == dx_rd);
    assign hazard  = dx_is_load && (dx_rd != ZERO_REG) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble controller: multdiv wait with timeout plus
// single-cycle load-use stall. Only state and md_cycles are registered;
// every other output is decoded combinationally from them and the inputs.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dx_is_md,
    input  logic       dx_is_load,
    input  logic [4:0] dx_rd,
    input  logic [4:0] fd_rs1,
    input  logic [4:0] fd_rs2,
    input  logic       fd_use_rs1,
    input  logic       fd_use_rs2,
    input  logic       md_ready,
    output logic       md_start,
    output logic       en_pc,
    output logic       en_fd,
    output logic       en_dx,
    output logic       en_xm,
    output logic       en_mw,
    output logic       dx_nop,
    output logic       xm_nop,
    output logic       xm_sel_md,
    output logic       md_timeout,
    output logic [5:0] md_cycles
);

    localparam logic [5:0] TIMEOUT_CNT = 6'(MD_TIMEOUT - 1);

    state_t state;
    logic   lu_hazard;
    logic   tout;
    logic   release_op;

    load_use_detect u_lud (
        .dx_is_load (dx_is_load),
        .dx_rd      (dx_rd),
        .fd_rs1     (fd_rs1),
        .fd_rs2     (fd_rs2),
        .fd_use_rs1 (fd_use_rs1),
        .fd_use_rs2 (fd_use_rs2),
        .hazard     (lu_hazard)
    );

    // A stuck multdiv is let go once the counter reaches the limit
    assign tout       = (state == WAIT) && !md_ready && (md_cycles == TIMEOUT_CNT);
    assign release_op = (state == WAIT) && (md_ready || tout);

    // Output decode; everything is forced low while reset is held
    always_comb begin
        md_start   = 1'b0;
        en_pc      = 1'b0;
        en_fd      = 1'b0;
        en_dx      = 1'b0;
        en_xm      = 1'b0;
        en_mw      = 1'b0;
        dx_nop     = 1'b0;
        xm_nop     = 1'b0;
        xm_sel_md  = 1'b0;
        md_timeout = 1'b0;
        if (reset) begin
            en_xm = 1'b1;
            en_mw = 1'b1;
            if (state == IDLE) begin
                if (dx_is_md) begin
                    // Launch op, freeze front end, bubble into XM
                    md_start = 1'b1;
                    xm_nop   = 1'b1;
                end else if (lu_hazard) begin
                    // Hold PC/FD one cycle, bubble into DX
                    en_dx  = 1'b1;
                    dx_nop = 1'b1;
                end else begin
                    en_pc = 1'b1;
                    en_fd = 1'b1;
                    en_dx = 1'b1;
                end
            end else if (release_op) begin
                en_pc      = 1'b1;
                en_fd      = 1'b1;
                en_dx      = 1'b1;
                xm_sel_md  = 1'b1;
                md_timeout = tout;
            end else begin
                xm_nop = 1'b1;
            end
        end
    end

    // State and WAIT-cycle counter; md_ready is only looked at in WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            md_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dx_is_md) begin
                        state     <= WAIT;
                        md_cycles <= '0;
                    end
                end
                WAIT: begin
                    if (release_op) begin
                        state <= IDLE;
                    end else if (md_cycles != MD_CYC_MAX) begin
                        md_cycles <= md_cycles + 6'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
